// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mole_round_ctrl
// Purpose  : Whack-a-mole round controller. Each round it requests one word
//            from the random generator (oEnb/iValid), waits
//            (iDelay+1)*WAIT_CYC cycles, then shows a mole in the chosen box
//            for a fixed window. A press on the mole's box scores a hit. A
//            press on any other box, or letting the window expire, counts as
//            a miss. The game ends after MAX_MISSES misses.
// Ports    : clk, reset_n            clock / async active-low reset
//            iStart                  start pulse (honoured in IDLE and OVER)
//            oEnb, iValid            generator request / word-valid handshake
//            iBox, iDelay, iColour   generator word fields
//            iHit                    one-hot button presses
//            oMoleOn, oMoleBox,      mole display
//            oMoleColour
//            oScore, oMisses,        game status
//            oGameOver
// Options  : `define SPEEDUP_EN shortens the show window by SHOW_CYC/8 after
//            every hit, with a floor of SHOW_CYC/4. The window resets to
//            SHOW_CYC when a game starts.
// Revision : 1.0 - initial release
// ============================================================================
module mole_round_ctrl #(
    parameter int WAIT_CYC   = 16,
    parameter int SHOW_CYC   = 64,
    parameter int SCORE_W    = 8,
    parameter int MAX_MISSES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               iStart,
    output logic               oEnb,
    input  logic               iValid,
    input  logic [2:0]         iBox,
    input  logic [1:0]         iDelay,
    input  logic [2:0]         iColour,
    input  logic [7:0]         iHit,
    output logic               oMoleOn,
    output logic [2:0]         oMoleBox,
    output logic [2:0]         oMoleColour,
    output logic [SCORE_W-1:0] oScore,
    output logic [3:0]         oMisses,
    output logic               oGameOver
);

    // The timer must hold the larger of the longest wait load and the show
    // load.
    localparam int c_tmr_max = (4 * WAIT_CYC > SHOW_CYC) ? 4 * WAIT_CYC : SHOW_CYC;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SHOW = 3'd3,
        S_OVER = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_tmr_w-1:0]   timer_q, timer_d;
    logic [2:0]           box_q, box_d;
    logic [2:0]           colour_q, colour_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           misses_q, misses_d;
    logic                 enb_q, enb_d;
    logic                 mole_on_q, mole_on_d;
    logic                 game_over_q, game_over_d;

    logic                 w_hit_ok;
    logic                 w_hit_wrong;
    logic [3:0]           w_misses_inc;
    logic [c_tmr_w-1:0]   w_show_load;

`ifdef SPEEDUP_EN
    localparam int c_len_w = $clog2(SHOW_CYC + 1);
    localparam int c_step  = SHOW_CYC / 8;
    localparam int c_floor = SHOW_CYC / 4;

    logic [c_len_w-1:0]   show_len_q, show_len_d;

    assign w_show_load = c_tmr_w'(show_len_q) - c_tmr_w'(1);
`else
    assign w_show_load = c_tmr_w'(SHOW_CYC - 1);
`endif

    // A correct bit takes priority over any wrong bits pressed in the same
    // cycle.
    assign w_hit_ok     = iHit[box_q];
    assign w_hit_wrong  = (|iHit) && !w_hit_ok;
    assign w_misses_inc = misses_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        box_d    = box_q;
        colour_d = colour_q;
        score_d  = score_q;
        misses_d = misses_q;
`ifdef SPEEDUP_EN
        show_len_d = show_len_q;
`endif

        case (state_q)
            S_IDLE, S_OVER: begin
                if (iStart) begin
                    score_d  = '0;
                    misses_d = '0;
                    state_d  = S_REQ;
`ifdef SPEEDUP_EN
                    show_len_d = c_len_w'(SHOW_CYC);
`endif
                end
            end

            S_REQ: begin
                if (iValid) begin
                    box_d    = iBox;
                    colour_d = iColour;
                    // Loaded with N-1 so that the mole appears exactly N
                    // cycles after the handshake.
                    timer_d  = c_tmr_w'((int'(iDelay) + 1) * WAIT_CYC - 1);
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
                if (timer_q == '0) begin
                    timer_d = w_show_load;
                    state_d = S_SHOW;
                end else begin
                    timer_d = timer_q - c_tmr_w'(1);
                end
            end

            S_SHOW: begin
                if (w_hit_ok) begin
                    if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    timer_d = '0;
                    state_d = S_REQ;
`ifdef SPEEDUP_EN
                    if (show_len_q >= c_len_w'(c_floor + c_step)) begin
                        show_len_d = show_len_q - c_len_w'(c_step);
                    end else begin
                        show_len_d = c_len_w'(c_floor);
                    end
`endif
                end else if (w_hit_wrong || (timer_q == '0)) begin
                    misses_d = w_misses_inc;
                    timer_d  = '0;
                    state_d  = (w_misses_inc == 4'(MAX_MISSES)) ? S_OVER : S_REQ;
                end else begin
                    timer_d = timer_q - c_tmr_w'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state, so each one changes in
        // the same cycle as the state transition that governs it.
        enb_d       = (state_d == S_REQ);
        mole_on_d   = (state_d == S_SHOW);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            box_q       <= '0;
            colour_q    <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            enb_q       <= 1'b0;
            mole_on_q   <= 1'b0;
            game_over_q <= 1'b0;
`ifdef SPEEDUP_EN
            show_len_q  <= c_len_w'(SHOW_CYC);
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            box_q       <= box_d;
            colour_q    <= colour_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            enb_q       <= enb_d;
            mole_on_q   <= mole_on_d;
            game_over_q <= game_over_d;
`ifdef SPEEDUP_EN
            show_len_q  <= show_len_d;
`endif
        end
    end

    assign oEnb        = enb_q;
    assign oMoleOn     = mole_on_q;
    assign oMoleBox    = box_q;
    assign oMoleColour = colour_q;
    assign oScore      = score_q;
    assign oMisses     = misses_q;
    assign oGameOver   = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mole_round_ctrl
// Purpose  : Directed self-checking bench for mole_round_ctrl (default
//            parameters: WAIT_CYC=16, SHOW_CYC=64, MAX_MISSES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mole_round_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       iStart;
    logic       oEnb;
    logic       iValid;
    logic [2:0] iBox;
    logic [1:0] iDelay;
    logic [2:0] iColour;
    logic [7:0] iHit;
    logic       oMoleOn;
    logic [2:0] oMoleBox;
    logic [2:0] oMoleColour;
    logic [7:0] oScore;
    logic [3:0] oMisses;
    logic       oGameOver;

    int n_chk  = 0;
    int n_fail = 0;

    mole_round_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .iStart      (iStart),
        .oEnb        (oEnb),
        .iValid      (iValid),
        .iBox        (iBox),
        .iDelay      (iDelay),
        .iColour     (iColour),
        .iHit        (iHit),
        .oMoleOn     (oMoleOn),
        .oMoleBox    (oMoleBox),
        .oMoleColour (oMoleColour),
        .oScore      (oScore),
        .oMisses     (oMisses),
        .oGameOver   (oGameOver)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_mole(input string tag);
        int n = 0;
        while (!oMoleOn && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(oMoleOn), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enb"},    32'(oEnb),        32'd0);
        chk({tag, "_moleon"}, 32'(oMoleOn),     32'd0);
        chk({tag, "_box"},    32'(oMoleBox),    32'd0);
        chk({tag, "_colour"}, 32'(oMoleColour), 32'd0);
        chk({tag, "_score"},  32'(oScore),      32'd0);
        chk({tag, "_misses"}, 32'(oMisses),     32'd0);
        chk({tag, "_over"},   32'(oGameOver),   32'd0);
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        iStart  = 1'b0;
        iValid  = 1'b0;
        iBox    = 3'd0;
        iDelay  = 2'd0;
        iColour = 3'd0;
        iHit    = 8'h00;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Round 1: handshake with box 5, delay 2, then a correct hit.
        iValid  = 1'b1;
        iBox    = 3'd5;
        iDelay  = 2'd2;
        iColour = 3'd3;
        iStart  = 1'b1;
        tick();
        iStart = 1'b0;
        chk("start_enb", 32'(oEnb), 32'd1);
        tick();                                // handshake edge
        chk("enb_one_cycle", 32'(oEnb), 32'd0);
        repeat (10) tick();
        iHit = 8'h20;                          // early press, ignored in WAIT
        tick();
        iHit = 8'h00;
        repeat (36) tick();                    // 47 edges after handshake
        chk("pre_show_off", 32'(oMoleOn), 32'd0);
        chk("wait_press_ignored", 32'(oScore), 32'd0);
        tick();                                // 48th edge
        chk("show_on_48", 32'(oMoleOn), 32'd1);
        chk("show_box", 32'(oMoleBox), 32'd5);
        chk("show_colour", 32'(oMoleColour), 32'd3);
        iHit   = 8'h20;
        iDelay = 2'd0;
        tick();
        iHit = 8'h00;
        chk("hit_score", 32'(oScore), 32'd1);
        chk("hit_moleoff", 32'(oMoleOn), 32'd0);
        chk("hit_back_req", 32'(oEnb), 32'd1);

        // Round 2: delay 0, no press; window must be exactly 64 cycles.
        tick();                                // handshake
        repeat (15) tick();
        chk("r2_pre_show_off", 32'(oMoleOn), 32'd0);
        tick();
        chk("r2_show_on_16", 32'(oMoleOn), 32'd1);
        cnt = 1;
        while (cnt < 200) begin
            tick();
            if (!oMoleOn) break;
            cnt++;
        end
        chk("timeout_window", 32'(cnt), 32'd64);
        chk("timeout_miss", 32'(oMisses), 32'd1);
        chk("timeout_score", 32'(oScore), 32'd1);

        // Round 3: press 8'h21 on the final visible cycle; the hit wins.
        wait_mole("r3_wait");
        repeat (63) tick();
        chk("r3_still_on", 32'(oMoleOn), 32'd1);
        iHit = 8'h21;
        tick();
        iHit = 8'h00;
        chk("tie_score", 32'(oScore), 32'd2);
        chk("tie_misses", 32'(oMisses), 32'd1);
        chk("tie_moleoff", 32'(oMoleOn), 32'd0);

        // iStart in REQ is ignored.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("start_ignored_score", 32'(oScore), 32'd2);
        chk("start_ignored_misses", 32'(oMisses), 32'd1);

        // Two wrong-box presses take misses to 3 and end the game.
        wait_mole("r4_wait");
        iHit = 8'h01;
        tick();
        iHit = 8'h00;
        chk("wrong1_misses", 32'(oMisses), 32'd2);
        chk("wrong1_over", 32'(oGameOver), 32'd0);
        wait_mole("r5_wait");
        iHit = 8'h81;
        tick();
        iHit = 8'h00;
        chk("wrong2_misses", 32'(oMisses), 32'd3);
        chk("over_flag", 32'(oGameOver), 32'd1);
        chk("over_enb", 32'(oEnb), 32'd0);
        chk("over_moleoff", 32'(oMoleOn), 32'd0);

        // OVER ignores iValid and iHit.
        iHit = 8'h20;
        repeat (5) tick();
        iHit = 8'h00;
        tick();
        chk("over_hold_score", 32'(oScore), 32'd2);
        chk("over_hold_misses", 32'(oMisses), 32'd3);
        chk("over_hold_flag", 32'(oGameOver), 32'd1);
        chk("over_hold_enb", 32'(oEnb), 32'd0);

        // Restart from OVER.
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("restart_score", 32'(oScore), 32'd0);
        chk("restart_misses", 32'(oMisses), 32'd0);
        chk("restart_over", 32'(oGameOver), 32'd0);
        chk("restart_enb", 32'(oEnb), 32'd1);

        // One hit, then reset asynchronously in the middle of SHOW.
        wait_mole("r6_wait");
        iHit = 8'h20;
        tick();
        iHit = 8'h00;
        chk("r6_score", 32'(oScore), 32'd1);
        wait_mole("r7_wait");
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        iValid = 1'b0;

`ifdef SPEEDUP_EN
        // Seven consecutive hits, each pressed on the last cycle the window
        // is expected to show: 64, 56, 48, 40, 32, 24, 16.
        reset_n = 1'b1;
        iValid  = 1'b1;
        iStart  = 1'b1;
        tick();
        iStart = 1'b0;
        for (int r = 0; r < 7; r++) begin
            int len;
            len = (64 - 8 * r > 16) ? 64 - 8 * r : 16;
            wait_mole("su_wait");
            repeat (len - 1) tick();
            chk("su_on_last", 32'(oMoleOn), 32'd1);
            chk("su_timer_last", 32'(dut.timer_q), 32'd0);
            iHit = 8'h20;
            tick();
            iHit = 8'h00;
        end
        chk("su_score", 32'(oScore), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
